// File: rtl/clock_time_if.sv
// Handshake-free bundle between the time controller and its tick/button sources and display.
// The master modport drives ticks and buttons; the slave modport returns the time, mode and strobes.
interface clock_time_if;
  logic       tick_1hz;
  logic       mode_btn;
  logic       inc_btn;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hour;
  logic [1:0] mode;
  logic       blink;
  logic       day_pulse;

  modport master (
    output tick_1hz, mode_btn, inc_btn,
    input  sec, min, hour, mode, blink, day_pulse
  );

  modport slave (
    input  tick_1hz, mode_btn, inc_btn,
    output sec, min, hour, mode, blink, day_pulse
  );
endinterface

// File: rtl/clock_time_ctrl.sv
// Time-of-day counters (sec/min/hour) advanced by a 1 Hz enable, with a RUN/SET_H/SET_M entry FSM.
// All outputs are registered and update on the clock edge that samples the tick or button edge.
module clock_time_ctrl #(
  parameter int SEC_MOD  = 60,
  parameter int MIN_MOD  = 60,
  parameter int HOUR_MOD = 24
) (
  input  logic         clk,
  input  logic         rst,
  clock_time_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SET_H = 2'd1,
    SET_M = 2'd2,
    BAD   = 2'd3
  } state_t;

  localparam logic [5:0] SEC_MAX  = 6'(SEC_MOD - 1);
  localparam logic [5:0] MIN_MAX  = 6'(MIN_MOD - 1);
  localparam logic [4:0] HOUR_MAX = 5'(HOUR_MOD - 1);

  state_t     state, state_nxt;
  logic       mode_prev, inc_prev;
  logic       mode_edge, inc_edge;
  logic [5:0] sec_q, sec_d;
  logic [5:0] min_q, min_d;
  logic [4:0] hour_q, hour_d;
  logic       blink_q, blink_d;
  logic       day_q, day_d;

  assign mode_edge = bus.mode_btn & ~mode_prev;
  assign inc_edge  = bus.inc_btn & ~inc_prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      mode_prev <= 1'b0;
      inc_prev  <= 1'b0;
      sec_q     <= '0;
      min_q     <= '0;
      hour_q    <= '0;
      blink_q   <= 1'b1;
      day_q     <= 1'b0;
    end else begin
      state     <= state_nxt;
      mode_prev <= bus.mode_btn;
      inc_prev  <= bus.inc_btn;
      sec_q     <= sec_d;
      min_q     <= min_d;
      hour_q    <= hour_d;
      blink_q   <= blink_d;
      day_q     <= day_d;
    end
  end

  always_comb begin
    state_nxt = state;
    sec_d     = sec_q;
    min_d     = min_q;
    hour_d    = hour_q;
    blink_d   = blink_q;
    day_d     = 1'b0;

    case (state)
      RUN: begin
        // A tick coinciding with a mode edge still advances time before leaving RUN.
        if (bus.tick_1hz) begin
          if (sec_q == SEC_MAX) begin
            sec_d = '0;
            if (min_q == MIN_MAX) begin
              min_d = '0;
              if (hour_q == HOUR_MAX) begin
                hour_d = '0;
                day_d  = 1'b1;
              end else begin
                hour_d = hour_q + 5'd1;
              end
            end else begin
              min_d = min_q + 6'd1;
            end
          end else begin
            sec_d = sec_q + 6'd1;
          end
        end
        if (mode_edge) state_nxt = SET_H;
      end
      SET_H: begin
        if (mode_edge)     state_nxt = SET_M;
        else if (inc_edge) hour_d = (hour_q == HOUR_MAX) ? 5'd0 : hour_q + 5'd1;
      end
      SET_M: begin
        if (mode_edge) begin
          state_nxt = RUN;
          sec_d     = '0;
        end else if (inc_edge) begin
          min_d = (min_q == MIN_MAX) ? 6'd0 : min_q + 6'd1;
        end
      end
      default: state_nxt = RUN;
    endcase

    // Field stays visible right after any mode change or increment.
    if (state_nxt != state || state_nxt == RUN || inc_edge) blink_d = 1'b1;
    else if (bus.tick_1hz)                                   blink_d = ~blink_q;
  end

  assign bus.sec       = sec_q;
  assign bus.min       = min_q;
  assign bus.hour      = hour_q;
  assign bus.mode      = state;
  assign bus.blink     = blink_q;
  assign bus.day_pulse = day_q;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Bench for clock_time_ctrl: vector table, directed corner sequences and random stimulus
// checked against a time-of-day model that counts seconds of the day.
module tb_clock_time_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  clock_time_if bus();

  clock_time_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  int m_sec, m_min, m_hour, m_mode;
  bit m_blink, m_day, m_pm, m_pi;

  typedef struct {
    bit tick, mb, ib;
    int sec, min, hour, mode, blink, day;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".sec"},   int'(bus.sec),       m_sec);
    chk({tag, ".min"},   int'(bus.min),       m_min);
    chk({tag, ".hour"},  int'(bus.hour),      m_hour);
    chk({tag, ".mode"},  int'(bus.mode),      m_mode);
    chk({tag, ".blink"}, int'(bus.blink),     int'(m_blink));
    chk({tag, ".day"},   int'(bus.day_pulse), int'(m_day));
  endtask

  task automatic model_reset();
    m_sec = 0; m_min = 0; m_hour = 0; m_mode = 0;
    m_blink = 1'b1; m_day = 1'b0; m_pm = 1'b0; m_pi = 1'b0;
  endtask

  task automatic model_step(input bit t, input bit mb, input bit ib);
    bit me, ie;
    int tod, next_mode;
    me = mb & ~m_pm;
    ie = ib & ~m_pi;
    m_pm = mb;
    m_pi = ib;
    m_day = 1'b0;
    next_mode = m_mode;
    case (m_mode)
      0: begin
        if (t) begin
          tod = m_hour * 3600 + m_min * 60 + m_sec;
          if (tod == 86399) m_day = 1'b1;
          tod = (tod + 1) % 86400;
          m_hour = tod / 3600;
          m_min  = (tod / 60) % 60;
          m_sec  = tod % 60;
        end
        if (me) next_mode = 1;
      end
      1: begin
        if (me)      next_mode = 2;
        else if (ie) m_hour = (m_hour + 1) % 24;
      end
      default: begin
        if (me) begin
          next_mode = 0;
          m_sec = 0;
        end else if (ie) begin
          m_min = (m_min + 1) % 60;
        end
      end
    endcase
    if (next_mode != m_mode || next_mode == 0 || ie) m_blink = 1'b1;
    else if (t)                                       m_blink = ~m_blink;
    m_mode = next_mode;
  endtask

  // Called at a falling edge; drives inputs for one full clock and checks at the next falling edge.
  task automatic cycle(input bit t, input bit mb, input bit ib);
    bus.tick_1hz = t;
    bus.mode_btn = mb;
    bus.inc_btn  = ib;
    @(negedge clk);
    model_step(t, mb, ib);
    chk_model("model");
  endtask

  task automatic do_reset(input bit mb, input bit ib);
    bus.tick_1hz = 1'b0;
    bus.mode_btn = mb;
    bus.inc_btn  = ib;
    rst = 1'b0;
    #2;
    model_reset();
    chk_model("reset");
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic press_mode();
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
  endtask

  task automatic press_inc();
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    bit mb_r, ib_r, t_r;

    //          tick mb ib  sec min hour mode blink day
    vecs[0]  = '{1, 0, 0,   1,  0,  0,   0,   1,    0};
    vecs[1]  = '{0, 1, 0,   1,  0,  0,   1,   1,    0};
    vecs[2]  = '{1, 1, 0,   1,  0,  0,   1,   0,    0};
    vecs[3]  = '{0, 0, 1,   1,  0,  1,   1,   1,    0};
    vecs[4]  = '{1, 0, 1,   1,  0,  1,   1,   0,    0};
    vecs[5]  = '{0, 0, 0,   1,  0,  1,   1,   0,    0};
    vecs[6]  = '{0, 1, 1,   1,  0,  1,   2,   1,    0};
    vecs[7]  = '{1, 0, 0,   1,  0,  1,   2,   0,    0};
    vecs[8]  = '{0, 0, 1,   1,  1,  1,   2,   1,    0};
    vecs[9]  = '{0, 0, 0,   1,  1,  1,   2,   1,    0};
    vecs[10] = '{0, 1, 0,   0,  1,  1,   0,   1,    0};
    vecs[11] = '{1, 0, 0,   1,  1,  1,   0,   1,    0};
    vecs[12] = '{1, 1, 0,   2,  1,  1,   1,   1,    0};
    vecs[13] = '{0, 0, 0,   2,  1,  1,   1,   1,    0};

    rst = 1'b1;
    @(negedge clk);
    do_reset(1'b0, 1'b0);

    foreach (vecs[i]) begin
      cycle(vecs[i].tick, vecs[i].mb, vecs[i].ib);
      chk($sformatf("vec%0d.sec", i),   int'(bus.sec),       vecs[i].sec);
      chk($sformatf("vec%0d.min", i),   int'(bus.min),       vecs[i].min);
      chk($sformatf("vec%0d.hour", i),  int'(bus.hour),      vecs[i].hour);
      chk($sformatf("vec%0d.mode", i),  int'(bus.mode),      vecs[i].mode);
      chk($sformatf("vec%0d.blink", i), int'(bus.blink),     vecs[i].blink);
      chk($sformatf("vec%0d.day", i),   int'(bus.day_pulse), vecs[i].day);
    end

    // Seconds carry into minutes.
    do_reset(1'b0, 1'b0);
    ticks(59);
    chk("s59.sec", int'(bus.sec), 59);
    chk("s59.min", int'(bus.min), 0);
    ticks(1);
    chk("carry.sec", int'(bus.sec), 0);
    chk("carry.min", int'(bus.min), 1);
    chk("carry.day", int'(bus.day_pulse), 0);

    // Preload 23:59 through set mode, then roll over the day.
    do_reset(1'b0, 1'b0);
    press_mode();
    repeat (23) press_inc();
    press_mode();
    repeat (59) press_inc();
    chk("preload.hour", int'(bus.hour), 23);
    chk("preload.min",  int'(bus.min), 59);
    chk("preload.day",  int'(bus.day_pulse), 0);
    press_mode();
    chk("preload.mode", int'(bus.mode), 0);
    chk("preload.sec",  int'(bus.sec), 0);
    ticks(59);
    chk("pre_roll.sec", int'(bus.sec), 59);
    chk("pre_roll.day", int'(bus.day_pulse), 0);
    cycle(1'b1, 1'b0, 1'b0);
    chk("roll.hour", int'(bus.hour), 0);
    chk("roll.min",  int'(bus.min), 0);
    chk("roll.sec",  int'(bus.sec), 0);
    chk("roll.day",  int'(bus.day_pulse), 1);
    cycle(1'b0, 1'b0, 1'b0);
    chk("roll.day_end", int'(bus.day_pulse), 0);

    // Hour wraps through 24 in SET_H; time frozen against ticks.
    do_reset(1'b0, 1'b0);
    ticks(5);
    press_mode();
    repeat (25) press_inc();
    chk("seth.hour", int'(bus.hour), 1);
    ticks(3);
    chk("seth.frozen_sec", int'(bus.sec), 5);
    chk("seth.mode", int'(bus.mode), 1);

    // Minute wrap in SET_M does not carry into hours.
    press_mode();
    repeat (59) press_inc();
    chk("setm.min59", int'(bus.min), 59);
    press_inc();
    chk("setm.wrap_min",  int'(bus.min), 0);
    chk("setm.wrap_hour", int'(bus.hour), 1);
    chk("setm.wrap_day",  int'(bus.day_pulse), 0);
    press_mode();
    chk("setm.exit_mode", int'(bus.mode), 0);
    chk("setm.exit_sec",  int'(bus.sec), 0);

    // Mode and inc edges together: mode wins.
    press_mode();
    cycle(1'b0, 1'b1, 1'b1);
    chk("both.mode", int'(bus.mode), 2);
    chk("both.hour", int'(bus.hour), 1);
    cycle(1'b0, 1'b0, 1'b0);

    // Reset while in SET_M with blink low.
    cycle(1'b1, 1'b0, 1'b0);
    chk("pre_rst.blink", int'(bus.blink), 0);
    chk("pre_rst.mode",  int'(bus.mode), 2);
    do_reset(1'b0, 1'b0);
    chk("rst.mode",  int'(bus.mode), 0);
    chk("rst.blink", int'(bus.blink), 1);
    chk("rst.hour",  int'(bus.hour), 0);
    chk("rst.min",   int'(bus.min), 0);
    cycle(1'b0, 1'b0, 1'b0);

    // Button held through reset release yields one edge.
    do_reset(1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    chk("held.mode", int'(bus.mode), 1);
    cycle(1'b0, 1'b1, 1'b0);
    chk("held.no_second_edge", int'(bus.mode), 1);

    // Random traffic against the model.
    do_reset(1'b0, 1'b0);
    mb_r = 1'b0;
    ib_r = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      t_r = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 24) == 0) mb_r = ~mb_r;
      if ($urandom_range(0, 3) == 0)  ib_r = ~ib_r;
      if ($urandom_range(0, 1499) == 0) begin
        do_reset(1'b0, 1'b0);
        mb_r = 1'b0;
        ib_r = 1'b0;
      end else begin
        cycle(t_r, mb_r, ib_r);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
